// File: rtl/lab7_2_timer_ctrl.sv
// Sequencing controller for the lab7_2 countdown timer: preset editing, counter
// load/decrement commands, display source select and end-of-count LED flash.
//
// state  | meaning
// IDLE   | waiting; SSD shows preset, start_stop begins a countdown if preset is nonzero
// SET    | preset edit mode while set is held
// RUN    | counting down; first cycle issues load
// PAUSE  | count frozen, waiting for resume or stop
// DONE   | count reached zero; endled flashes for DONE_TICKS ticks
module lab7_2_timer_ctrl #(
  parameter int DONE_TICKS = 10,
  parameter int HOUR_MAX   = 23,
  parameter int MIN_MAX    = 59
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        set,
  input  logic        inc_hour,
  input  logic        inc_min,
  input  logic        start_stop,
  input  logic        pause_resume,
  input  logic        cnt_zero,
  output logic        load,
  output logic        dec,
  output logic [3:0]  p_h1,
  output logic [3:0]  p_h0,
  output logic [3:0]  p_m1,
  output logic [3:0]  p_m0,
  output logic        disp_sel,
  output logic [2:0]  state,
  output logic [14:0] endled
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int FW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

  state_t        state_q, state_nxt;
  logic          first_q;
  logic [7:0]    hour_q, min_q;
  logic [14:0]   endled_q;
  logic [FW-1:0] flash_q;
  logic          flash_last;
  logic          preset_nz;

  // BCD +1 with units carry and wrap back to 00 after max
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input int max);
    if ((int'(v[7:4]) * 10 + int'(v[3:0])) >= max) return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign preset_nz  = (hour_q != 8'h00) || (min_q != 8'h00);
  assign flash_last = (flash_q == FW'(DONE_TICKS - 1));

  always_comb begin
    state_nxt = state_q;
    dec       = 1'b0;
    disp_sel  = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (set) state_nxt = S_SET;
        else if (start_stop && preset_nz) state_nxt = S_RUN;
      end
      S_SET: begin
        if (!set) state_nxt = S_IDLE;
      end
      S_RUN: begin
        disp_sel = 1'b0;
        // cnt_zero is stale during the load cycle, so it is only honoured afterwards
        if (!first_q && cnt_zero) state_nxt = S_DONE;
        else if (start_stop) state_nxt = S_IDLE;
        else if (pause_resume) state_nxt = S_PAUSE;
        else dec = tick & ~cnt_zero & ~first_q;
      end
      S_PAUSE: begin
        disp_sel = 1'b0;
        if (start_stop) state_nxt = S_IDLE;
        else if (pause_resume) state_nxt = S_RUN;
      end
      S_DONE: begin
        disp_sel = 1'b0;
        if (start_stop || (tick && flash_last)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      first_q <= (state_q == S_IDLE) && (state_nxt == S_RUN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_q <= 8'h00;
      min_q  <= 8'h00;
    end else if (state_q == S_SET) begin
      if (inc_hour) hour_q <= bcd_inc(hour_q, HOUR_MAX);
      if (inc_min)  min_q  <= bcd_inc(min_q, MIN_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      endled_q <= 15'h0000;
      flash_q  <= '0;
    end else if (state_q != S_DONE && state_nxt == S_DONE) begin
      endled_q <= 15'h7FFF;
      flash_q  <= '0;
    end else if (state_q == S_DONE && state_nxt == S_DONE) begin
      if (tick) begin
        endled_q <= ~endled_q;
        flash_q  <= flash_q + FW'(1);
      end
    end else begin
      endled_q <= 15'h0000;
      flash_q  <= '0;
    end
  end

  assign load   = (state_q == S_RUN) && first_q;
  assign state  = state_q;
  assign endled = endled_q;
  assign p_h1   = hour_q[7:4];
  assign p_h0   = hour_q[3:0];
  assign p_m1   = min_q[7:4];
  assign p_m0   = min_q[3:0];

endmodule
